// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: RV32I width codes,
// controller states and access classification helpers.
package dmem_access_ctrl_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_LOAD_RSP = 3'd2,
    S_WRITE    = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  // Unsigned widths exist only for loads; stores with them are illegal.
  function automatic logic access_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: access_illegal = 1'b0;
      F3_BU, F3_HU:     access_illegal = we;
      default:          access_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   access_misaligned = off[0];
      2'b10:   access_misaligned = (off != 2'b00);
      default: access_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational byte-lane handling: load extract/extend and sub-word store merge
// into a full memory word.
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [4:0]  bit_off;

  assign bit_off   = {byte_off, 3'b000};
  assign lane_byte = word[bit_off +: 8];
  assign lane_half = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h0, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0, lane_half};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_data = word;
    case (funct3)
      F3_B: store_data[bit_off +: 8] = wdata[7:0];
      F3_H: begin
        if (byte_off[1]) store_data[31:16] = wdata[15:0];
        else             store_data[15:0]  = wdata[15:0];
      end
      F3_W:    store_data = wdata;
      default: store_data = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer for a word-only synchronous-read data RAM: sub-word
// stores become read-modify-write, sub-word loads are extended, bad accesses flagged.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     req_ready,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic                     rsp_err,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  state_t state, state_nx;

  logic                     cap_we;
  logic [2:0]               cap_f3;
  logic [ADDRESS_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0]    cap_wdata;
  logic                     req_bad;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    store_data;

  assign req_bad = access_illegal(funct3, req_we) | access_misaligned(funct3, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cap_we    <= 1'b0;
      cap_f3    <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_f3    <= funct3;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                      state_nx = S_ERR;
          else if (req_we && funct3 == F3_W) state_nx = S_WRITE;
          else                              state_nx = S_READ;
        end
      end
      S_READ: begin
        mem_en   = 1'b1;
        state_nx = cap_we ? S_WRITE : S_LOAD_RSP;
      end
      S_LOAD_RSP: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      S_WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // RMW merge reads mem_rdata directly: the READ cycle was the one just before WRITE.
  mem_lane_align u_lane_align (
    .funct3     (cap_f3),
    .byte_off   (cap_addr[1:0]),
    .word       (mem_rdata),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign stall     = req_valid & ~rsp_valid;
  assign mem_addr  = cap_addr[ADDRESS_WIDTH-1:2];
  assign mem_wdata = (state == S_WRITE)    ? store_data : '0;
  assign rsp_rdata = (state == S_LOAD_RSP) ? load_data  : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small synchronous-read word RAM model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = -1;
  logic [31:0] mem [0:255];

  dmem_access_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        last_wr_cyc <= cyc;
      end
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Starts just after a clock edge with the DUT idle; returns idle with req_valid low.
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_nmem, output int rsp_cyc);
    int lat, nmem;
    logic stall_ok, rdy0;
    logic [31:0] rd;
    logic er;
    lat = -1; nmem = 0; stall_ok = 1'b1; rd = '0; er = 1'b0; rsp_cyc = -1; rdy0 = 1'b0;
    req_valid = 1'b1; req_we = we; funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      #1;
      if (c == 0) rdy0 = req_ready;
      if (mem_en) nmem++;
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; er = rsp_err; rsp_cyc = cyc;
        if (stall) stall_ok = 1'b0;
      end else if (!stall) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    #1;
    check_eq({tag, " ready0"}, 32'(rdy0), 32'd1);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " err"}, 32'(er), 32'(exp_err));
    check_eq({tag, " rdata"}, rd, exp_rdata);
    check_eq({tag, " mem_en cycles"}, 32'(nmem), 32'(exp_nmem));
    check_eq({tag, " stall"}, 32'(stall_ok), 32'd1);
    check_eq({tag, " ready after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int rc, rc2, s0, wsnap;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst req_ready", 32'(req_ready), 32'd1);
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst mem_en", 32'(mem_en), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // word store then load back
    access("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 1'b0, 32'h0, 1, rc);
    check_eq("sw mem word", mem[8'h40], 32'hDEADBEEF);
    check_eq("sw write cycle", 32'(last_wr_cyc), 32'(rc));
    access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1, rc);

    // sub-word RMW
    access("sw2", 1'b1, 3'b010, 32'h100, 32'h11223344, 1, 1'b0, 32'h0, 1, rc);
    access("sb", 1'b1, 3'b000, 32'h102, 32'h123456AA, 2, 1'b0, 32'h0, 2, rc);
    check_eq("sb mem word", mem[8'h40], 32'h11AA3344);
    check_eq("sb write cycle", 32'(last_wr_cyc), 32'(rc));
    access("sh", 1'b1, 3'b001, 32'h102, 32'h12345566, 2, 1'b0, 32'h0, 2, rc);
    check_eq("sh mem word", mem[8'h40], 32'h55663344);
    access("sb0", 1'b1, 3'b000, 32'h100, 32'h000000EE, 2, 1'b0, 32'h0, 2, rc);
    check_eq("sb0 mem word", mem[8'h40], 32'h556633EE);

    // load extension
    access("sw3", 1'b1, 3'b010, 32'h200, 32'h80A0B0C0, 1, 1'b0, 32'h0, 1, rc);
    access("lb", 1'b0, 3'b000, 32'h203, 32'h0, 2, 1'b0, 32'hFFFFFF80, 1, rc);
    access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 2, 1'b0, 32'h00000080, 1, rc);
    access("lh", 1'b0, 3'b001, 32'h200, 32'h0, 2, 1'b0, 32'hFFFFB0C0, 1, rc);
    access("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 2, 1'b0, 32'h000080A0, 1, rc);
    access("lb1", 1'b0, 3'b000, 32'h201, 32'h0, 2, 1'b0, 32'hFFFFFFB0, 1, rc);
    access("lbu0", 1'b0, 3'b100, 32'h200, 32'h0, 2, 1'b0, 32'h000000C0, 1, rc);

    // errors
    wsnap = wr_cnt;
    access("lw mis", 1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b1, 32'h0, 0, rc);
    access("sh mis", 1'b1, 3'b001, 32'h103, 32'hFFFF, 1, 1'b1, 32'h0, 0, rc);
    access("f3 011", 1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, rc);
    access("sbu ill", 1'b1, 3'b100, 32'h100, 32'h77, 1, 1'b1, 32'h0, 0, rc);
    access("lh mis", 1'b0, 3'b001, 32'h201, 32'h0, 1, 1'b1, 32'h0, 0, rc);
    check_eq("err no writes", 32'(wr_cnt), 32'(wsnap));
    check_eq("err mem word", mem[8'h40], 32'h556633EE);

    // reset during the read phase of a halfword RMW
    wsnap = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'h0000ABCD;
    @(posedge clk); #1;
    check_eq("rmw rst read en", 32'(mem_en), 32'd1);
    check_eq("rmw rst read we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rmw rst rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check_eq("rmw rst ready", 32'(req_ready), 32'd1);
    check_eq("rmw rst rsp after", 32'(rsp_valid), 32'd0);
    check_eq("rmw rst mem_en after", 32'(mem_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rmw rst no write", 32'(wr_cnt), 32'(wsnap));
    check_eq("rmw rst word", mem[8'h40], 32'h556633EE);

    // back-to-back loads
    s0 = cyc;
    access("b2b1", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'h556633EE, 1, rc);
    access("b2b2", 1'b0, 3'b010, 32'h200, 32'h0, 2, 1'b0, 32'h80A0B0C0, 1, rc2);
    check_eq("b2b rsp1 cycle", 32'(rc - s0), 32'd2);
    check_eq("b2b rsp2 cycle", 32'(rc2 - s0), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the pipeline memory stage and a word-only, single-port, synchronous-read data memory. Accepts one load/store per request, runs a read-modify-write for sub-word stores, sign/zero-extends sub-word loads and flags misaligned or illegal accesses. Drives the memory stage stall until the access completes.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory-stage access request; held stable until rsp_valid
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDRESS_WIDTH  byte address (ALU result)
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- req_ready  out  1  high only in IDLE
- stall  out  1  req_valid & ~rsp_valid
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  misaligned/illegal access, valid with rsp_valid
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write (qualified by mem_en)
- mem_addr  out  ADDRESS_WIDTH-2  word address
- mem_wdata  out  DATA_WIDTH  full-word write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read

## Operation
- States: IDLE, READ, LOAD_RSP, WRITE, ERR.
- IDLE: if req_valid, capture we, funct3, addr, wdata; classify:
  - illegal funct3 (011, 110, 111; or store with 100/101) -> ERR
  - misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) -> ERR
  - load -> READ; SW -> WRITE; SB/SH -> READ
- READ: mem_en=1, mem_we=0, mem_addr=captured addr[ADDRESS_WIDTH-1:2]; -> LOAD_RSP if load, else WRITE.
- LOAD_RSP: select byte lane addr[1:0] (half lane addr[1]) from mem_rdata; B/H sign-extend, BU/HU zero-extend, W pass; rsp_valid=1; -> IDLE.
- WRITE: mem_en=1, mem_we=1; SW writes captured wdata; SB/SH write mem_rdata (registered at READ->WRITE? no: sampled directly this cycle, since READ was the previous cycle) with the addressed lane(s) replaced by wdata[7:0]/wdata[15:0]; rsp_valid=1; -> IDLE.
- ERR: no memory access; rsp_valid=1, rsp_err=1, rsp_rdata=0; -> IDLE.
- mem_* decoded from state and captured registers only; no combinational path req_* -> mem_*.
- rst in any state: -> IDLE next edge, in-flight access abandoned, no rsp_valid, no write issued after the reset edge.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; capture regs 0.
- Acceptance edge = cycle 0.
- Load: READ cycle 1, rsp_valid cycle 2 (latency 2).
- SW: write + rsp_valid cycle 1 (latency 1).
- SB/SH: read cycle 1, merged write + rsp_valid cycle 2 (latency 2).
- Error: rsp_valid cycle 1, no mem_en.
- Back-to-back: next request accepted in the cycle after rsp_valid; at most one access in flight, 1 idle cycle minimum between completions.
- stall is combinational; it drops in the rsp_valid cycle so the pipeline advances on that edge.
- req_valid dropping mid-access is a protocol violation; controller ignores it and completes.

## Structure
- Shared package: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, lane-count constant.
- Sub-module mem_lane_align: combinational load extract/extend and store merge from (funct3, addr[1:0], word, wdata); reused by any later cached LSU.

## Test plan
- Store then load: SW 0xDEADBEEF @0x100, then LW @0x100 -> mem write word 0x40 data 0xDEADBEEF in cycle 1; load rsp_rdata=0xDEADBEEF in cycle 2.
- Sub-word store RMW: word 0x40 holds 0x11223344; SB 0xAA @0x102 -> read cycle 1, write 0x11AA3344 cycle 2, rsp_valid cycle 2.
- Load extension: word 0x80A0B0C0 @0x200; LB @0x203 -> 0xFFFFFF80; LBU @0x203 -> 0x00000080; LH @0x200 -> 0xFFFFB0C0; LHU @0x202 -> 0x000080A0.
- Errors: LW @0x101, SH @0x103, funct3=011 load -> rsp_err=1 cycle 1, rsp_rdata=0, mem_en never asserted.
- Reset mid-RMW: SH accepted, rst asserted in READ cycle -> no mem_we, no rsp_valid, req_ready=1 after reset edge.
- Back-to-back loads with stall: two LWs -> stall high cycles 0-1, low cycle 2; second accepted cycle 3, rsp cycle 5.
